// File: rtl/ysyx_25020047_mem_pkg.sv
// ============================================================================
// Module : ysyx_25020047_mem_pkg
// Brief  : Shared types, constants and range check for the memory responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25020047_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] c_lfsr_seed = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3
  localparam logic [7:0] c_lfsr_taps = 8'hB8;

  function automatic logic in_range(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] base,
                                    input logic [XLEN-1:0] span);
    logic [XLEN-1:0] limit;
    limit = base + span;
    return (addr >= base) && (addr < limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25020047_lfsr8.sv
// ============================================================================
// Module : ysyx_25020047_lfsr8
// Brief  : 8-bit maximal-length LFSR, reloaded with seed on rst.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020047_lfsr8
  import ysyx_25020047_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= seed;
    end else if (en) begin
      r_state <= {r_state[6:0], ^(r_state & c_lfsr_taps)};
    end
  end

  assign q = r_state;

endmodule

`default_nettype wire

// File: rtl/ysyx_25020047_mem_resp.sv
// ============================================================================
// Module : ysyx_25020047_mem_resp
// Brief  : Single-outstanding word memory responder with programmable latency.
//          Define MEM_RESP_RAND_LAT_EN to draw each latency from an LFSR.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020047_mem_resp
  import ysyx_25020047_mem_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE    = 32'h8000_0000,
  parameter int              DEPTH   = 1024,
  parameter int              LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_wstrb,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int              c_idx_w = $clog2(DEPTH);
  localparam logic [XLEN-1:0] c_span  = XLEN'(4 * DEPTH);

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic            r_wen;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_err;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic               w_in_range;
  logic [c_idx_w-1:0] w_idx;
  logic               w_commit;
  logic [3:0]         w_lat;

  assign w_in_range = in_range(r_addr, BASE, c_span);
  assign w_idx      = c_idx_w'((r_addr - BASE) >> 2);
  assign w_commit   = (r_state == BUSY) && (r_cnt == 4'd0);

`ifdef MEM_RESP_RAND_LAT_EN
  logic [7:0] w_lfsr;

  ysyx_25020047_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .seed (c_lfsr_seed),
    .q    (w_lfsr)
  );

  assign w_lat = w_lfsr[3:0];
`else
  assign w_lat = 4'(LATENCY);
`endif

  // Array is deliberately not reset; a reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && r_wen && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_wen       <= req_wen;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_cnt       <= w_lat;
            r_req_ready <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_in_range;
            r_resp_rdata <= (!r_wen && w_in_range) ? r_mem[w_idx] : '0;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020047_mem_resp.sv
// ============================================================================
// Module : tb_ysyx_25020047_mem_resp
// Brief  : Directed bench with a cycle-timed reference model for the responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020047_mem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIMIT = 32'h8000_1000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        req_valid  = 1'b0;
  logic        req_wen    = 1'b0;
  logic [31:0] req_addr   = '0;
  logic [31:0] req_wdata  = '0;
  logic [3:0]  req_wstrb  = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  ysyx_25020047_mem_resp #(
    .BASE    (BASE),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted at edge T answers after edge T+lat+1,
  // where the memory effect also lands; a reset before then cancels it.
  logic [31:0] mm [int];
  int          cyc = 0;
  bit          live = 0, pend = 0, done = 0;
  int          t_acc = 0, m_lat = 0;
  logic        m_wen = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_strb = '0;
  logic [7:0]  m_lfsr = 8'h00;

  task automatic commit();
    bit          inr;
    int          idx;
    logic [31:0] w;
    inr = (m_addr >= BASE) && (m_addr < LIMIT);
    idx = int'((m_addr - BASE) >> 2);
    m_err   = !inr;
    m_rdata = '0;
    if (inr && !m_wen) m_rdata = mm[idx];
    if (inr && m_wen) begin
      w = mm.exists(idx) ? mm[idx] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (m_strb[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
      mm[idx] = w;
    end
    done = 1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (live) begin
      chk("req_ready", 32'(req_ready), 32'(!pend));
      chk("resp_valid", 32'(resp_valid), 32'(pend && done));
      if (pend && done) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
    end
    if (rst) begin
      live   = 1;
      pend   = 0;
      m_lfsr = 8'hA5;
    end else if (live) begin
      if (pend && done) begin
        if (resp_ready) pend = 0;
      end else if (pend) begin
        if (cyc + 1 == t_acc + m_lat + 1) commit();
      end else if (req_valid) begin
        pend    = 1;
        done    = 0;
        t_acc   = cyc + 1;
`ifdef MEM_RESP_RAND_LAT_EN
        m_lat   = int'(m_lfsr[3:0]);
`else
        m_lat   = LAT;
`endif
        m_wen   = req_wen;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_strb  = req_wstrb;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic send(input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    bit ok;
    ok = 0;
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    req_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout %h: got req_ready 0 expected 1", addr);
    end
    @(posedge clk); #2;
    // Scramble request inputs after accept; the responder must ignore them.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    req_wen   = 1'($urandom);
  endtask

  task automatic get_resp(input int hold, output logic [31:0] d, output logic e, output int lat);
    lat = -1; d = '0; e = 1'b0;
    resp_ready = (hold == 0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k - 1; break; end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: got resp_valid 0 expected 1");
      resp_ready = 1'b1;
      return;
    end
    d = resp_rdata; e = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic xact(input string name, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                      input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic        e;
    int          l;
    send(wen, addr, wdata, strb);
    get_resp(hold, d, e, l);
    chk({name, "_rdata"}, d, exp_d);
    chk({name, "_err"}, 32'(e), 32'(exp_e));
`ifdef MEM_RESP_RAND_LAT_EN
    chk({name, "_lat_range"}, 32'(l >= 1 && l <= 16), 32'd1);
`else
    chk({name, "_lat"}, l, LAT + 1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          l;
    bit          seen;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    xact("t1_wr", 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xact("t1_rd", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);

    xact("t2_wr", 1'b1, 32'h8000_0004, 32'h0000_AB00, 4'b0010, 0, 32'h0, 1'b0);
    xact("t2_rd", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 32'hDEAD_ABEF, 1'b0);
    xact("t2_nop", 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0);
    xact("t2_rd2", 1'b0, 32'h8000_0006, 32'h0, 4'h0, 0, 32'hDEAD_ABEF, 1'b0);

    xact("t3_lo", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    xact("t3_hi", 1'b0, 32'h8000_1000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    xact("t3_w0", 1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0);
    xact("t3_wbad", 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
    xact("t3_r0", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h1122_3344, 1'b0);
    xact("t3_wlast", 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    xact("t3_rlast", 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);

    xact("t4_hold", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 5, 32'hDEAD_ABEF, 1'b0);
    chk("t4_after_valid", 32'(resp_valid), 32'd0);

    // Reset while the write is still waiting for its commit edge.
    xact("t5_prep", 1'b1, 32'h8000_0008, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 1'b0);
    send(1'b1, 32'h8000_0008, 32'h1234_5678, 4'hF);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    chk("t5_busy_rst_valid", 32'(resp_valid), 32'd0);
    chk("t5_busy_rst_ready", 32'(req_ready), 32'd1);
    xact("t5_rd", 1'b0, 32'h8000_0008, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0);

    // Reset while a response is being held.
    resp_ready = 1'b0;
    send(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1; break; end
    end
    chk("t5_resp_seen", 32'(seen), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    chk("t5_resp_rst_valid", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;

    // Back-to-back with req_valid held; inputs change mid-flight to the next request.
    req_wen = 1'b0; req_addr = 32'h8000_0004; req_wdata = 32'h0; req_wstrb = 4'h0;
    req_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready) begin seen = 1; break; end
    end
    chk("t6_first_accept", 32'(seen), 32'd1);
    @(posedge clk); #2;
    req_wen = 1'b1; req_addr = 32'h8000_0008; req_wdata = 32'hA5A5_A5A5; req_wstrb = 4'hF;
    get_resp(0, d, e, l);
    chk("t6_first_rdata", d, 32'hDEAD_ABEF);
    chk("t6_first_err", 32'(e), 32'd0);
    chk("t6_second_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #2 req_valid = 1'b0;
    get_resp(0, d, e, l);
    chk("t6_second_rdata", d, 32'h0);
    chk("t6_second_err", 32'(e), 32'd0);
    xact("t6_rd", 1'b0, 32'h8000_0008, 32'h0, 4'h0, 0, 32'hA5A5_A5A5, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
